uart_frame_tx: RTL

- Transmit-side framer and 8N1 UART serializer for the host link.
- It takes a response request (destination address, length, payload bytes) from the internal register/readout logic and emits one frame on `tx`.
- A frame is prefix `0xDD`, address, length, payload, then checksum. This is the same frame format the host uses toward the board, in the opposite direction.
- It sits between the packet router's readout path and the `tx` pin.

---
 rtl/uart_frame_tx.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_tx.sv
// Host-link transmit framer: emits PREFIX, addr, len, payload, XOR checksum
// as back-to-back 8N1 UART bytes on tx.
module uart_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  PREFIX       = 8'hDD
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr_in,
  input  logic [7:0] len_in,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       tx
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] F_IDLE   = 3'd0;
  localparam logic [2:0] F_PREFIX = 3'd1;
  localparam logic [2:0] F_ADDR   = 3'd2;
  localparam logic [2:0] F_LEN    = 3'd3;
  localparam logic [2:0] F_DATA   = 3'd4;
  localparam logic [2:0] F_CRC    = 3'd5;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BITS  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [2:0]        frm_q, frm_d;
  logic [1:0]        ser_q, ser_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              load;
  logic [7:0]        load_byte;

  // Framer and serializer next-state logic; the framer only acts when the
  // serializer is empty (load cycle) or finishing a stop bit.
  always_comb begin
    frm_d     = frm_q;
    ser_d     = ser_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    chk_d     = chk_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_byte = 8'h00;

    case (ser_q)
      S_EMPTY: begin
        tx_d = 1'b1;
        case (frm_q)
          F_IDLE: begin
            if (start) begin
              addr_d    = addr_in;
              len_d     = len_in;
              cnt_d     = len_in;
              chk_d     = 8'h00;
              busy_d    = 1'b1;
              frm_d     = F_PREFIX;
              load      = 1'b1;
              load_byte = PREFIX;
            end
          end
          F_ADDR: begin
            load      = 1'b1;
            load_byte = addr_q;
            chk_d     = chk_q ^ addr_q;
          end
          F_LEN: begin
            load      = 1'b1;
            load_byte = len_q;
            chk_d     = chk_q ^ len_q;
          end
          F_DATA: begin
            if (data_valid && ready_q) begin
              load      = 1'b1;
              load_byte = data_in;
              chk_d     = chk_q ^ data_in;
              cnt_d     = cnt_q - 8'd1;
            end
          end
          F_CRC: begin
            load      = 1'b1;
            load_byte = chk_q;
          end
          default: ;
        endcase
        if (load) begin
          shift_d = load_byte;
          ser_d   = S_START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          bit_d  = 3'd0;
          ser_d  = S_BITS;
          tx_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_BITS: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            ser_d = S_STOP;
            tx_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          ser_d  = S_EMPTY;
          tx_d   = 1'b1;
          case (frm_q)
            F_PREFIX: frm_d = F_ADDR;
            F_ADDR:   frm_d = F_LEN;
            F_LEN:    frm_d = (len_q == 8'd0) ? F_CRC : F_DATA;
            F_DATA:   frm_d = (cnt_q == 8'd0) ? F_CRC : F_DATA;
            F_CRC: begin
              frm_d  = F_IDLE;
              busy_d = 1'b0;
              done_d = 1'b1;
            end
            default:  frm_d = F_IDLE;
          endcase
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
    endcase

    ready_d = (frm_d == F_DATA) && (ser_d == S_EMPTY);
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      frm_q   <= F_IDLE;
      ser_q   <= S_EMPTY;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      cnt_q   <= 8'd0;
      addr_q  <= 8'd0;
      len_q   <= 8'd0;
      chk_q   <= 8'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      frm_q   <= frm_d;
      ser_q   <= ser_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign data_ready = ready_q;
  assign frame_done = done_q;

endmodule
